macc_lsu: RTL

Parametrised memory-access stage sitting between EXU and WB; successor to the single-cycle pass-through memory stage. It adds sub-word loads and stores (byte/half/word, plus double when DATA_W=64), byte enables, sign/zero extension, misalignment detection, and a request/grant/response handshake to data memory with pipeline back-pressure. It also adds a bus-error/timeout exception path to WB. Non-memory instructions pass through with one cycle of registered latency.

---
 rtl/macc_lsu_if.sv | 27 ++
 rtl/macc_lsu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_lsu_if.sv
// Data-memory port of the load/store stage: request/grant/response handshake.
interface macc_lsu_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned LANES = DATA_W / 8;

  logic              req;
  logic              gnt;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/macc_lsu.sv
// Memory-access stage between EXU and WB: sub-word loads/stores with byte
// enables and extension, misalignment and bus-error/timeout exceptions,
// request/grant/response handshake and one-cycle registered pass-through.
module macc_lsu #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              rst_sys,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_rd_wen,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_mem_wreq,
  input  logic              i_mem_rreq,
  input  logic [1:0]        i_mem_size,
  input  logic              i_mem_unsigned,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_mem_wdata,
  macc_lsu_if.master        mem,
  output logic              o_wb_valid,
  output logic              o_rd_wen,
  output logic [4:0]        o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_exc,
  output logic [1:0]        o_exc_cause,
  output logic [ADDR_W-1:0] o_exc_addr
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(LANES);
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_LD_MIS  = 2'b00;
  localparam logic [1:0] CAUSE_BUS_ERR = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Transaction context captured at issue
  logic [1:0]        size_q;
  logic              uns_q;
  logic              rd_wen_q;
  logic [4:0]        rd_addr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              store_q;

  // Watchdog
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              expired;

  // Incoming request decode
  logic              take;
  logic              mem_op;
  logic              misaligned;
  logic [OFS_W-1:0]  ofs_in;
  int unsigned       nbytes_in;
  logic [LANES-1:0]  size_mask;
  logic [LANES-1:0]  be_in;
  logic [DATA_W-1:0] wdata_mask;
  logic [DATA_W-1:0] wdata_in;

  // Load data alignment and extension
  logic [OFS_W-1:0]  ofs_q;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] load_data;
  int unsigned       nbits;
  logic              sign;

  // FSM side effects
  logic              issue;
  logic              drop_req;
  logic              wb_fire;
  logic              wb_rd_wen_d;
  logic [4:0]        wb_rd_addr_d;
  logic [DATA_W-1:0] wb_data_d;
  logic              wb_exc_d;
  logic [1:0]        wb_cause_d;
  logic [ADDR_W-1:0] wb_exc_addr_d;

  assign o_ready = (state == IDLE);
  assign take    = i_valid & o_ready;
  assign mem_op  = i_mem_wreq | i_mem_rreq;
  assign ofs_q   = addr_q[OFS_W-1:0];
  assign cnt_inc = cnt + CNT_W'(1);
  assign expired = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // Byte enables, lane-positioned store data and alignment check for the incoming op
  always_comb begin
    ofs_in     = i_mem_addr[OFS_W-1:0];
    nbytes_in  = 1;
    size_mask  = '0;
    wdata_mask = '0;
    misaligned = 1'b0;
    case (i_mem_size)
      2'b00:   nbytes_in = 1;
      2'b01:   nbytes_in = 2;
      2'b10:   nbytes_in = 4;
      default: nbytes_in = LANES;
    endcase
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i < nbytes_in) size_mask[i] = 1'b1;
    end
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < 8 * nbytes_in) wdata_mask[i] = 1'b1;
    end
    be_in    = size_mask << ofs_in;
    wdata_in = (i_mem_wdata & wdata_mask) << {ofs_in, 3'b000};
    case (i_mem_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = i_mem_addr[0];
      2'b10:   misaligned = |i_mem_addr[1:0];
      default: misaligned = (DATA_W == 32) || (|i_mem_addr[2:0]);
    endcase
  end

  // Select the addressed bytes of the response and sign/zero extend them
  always_comb begin
    rd_shift  = mem.rdata >> {ofs_q, 3'b000};
    load_data = '0;
    case (size_q)
      2'b00:   nbits = 8;
      2'b01:   nbits = 16;
      2'b10:   nbits = 32;
      default: nbits = DATA_W;
    endcase
    sign = ~uns_q & rd_shift[nbits-1];
    for (int unsigned i = 0; i < DATA_W; i++) begin
      load_data[i] = (i < nbits) ? rd_shift[i] : sign;
    end
  end

  // State register
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and writeback result selection
  always_comb begin
    state_nxt     = state;
    issue         = 1'b0;
    drop_req      = 1'b0;
    wb_fire       = 1'b0;
    wb_rd_wen_d   = 1'b0;
    wb_rd_addr_d  = rd_addr_q;
    wb_data_d     = '0;
    wb_exc_d      = 1'b0;
    wb_cause_d    = CAUSE_LD_MIS;
    wb_exc_addr_d = '0;
    unique case (state)
      IDLE: begin
        if (take) begin
          if (!mem_op) begin
            wb_fire      = 1'b1;
            wb_rd_wen_d  = i_rd_wen;
            wb_rd_addr_d = i_rd_addr;
            wb_data_d    = i_alu_result;
          end else if (misaligned) begin
            wb_fire       = 1'b1;
            wb_rd_addr_d  = i_rd_addr;
            wb_exc_d      = 1'b1;
            wb_cause_d    = {1'b0, i_mem_wreq};
            wb_exc_addr_d = i_mem_addr;
          end else begin
            issue     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        // A timeout in the grant cycle wins so that no response is expected afterwards
        if (expired) begin
          drop_req      = 1'b1;
          wb_fire       = 1'b1;
          wb_exc_d      = 1'b1;
          wb_cause_d    = CAUSE_TIMEOUT;
          wb_exc_addr_d = addr_q;
          state_nxt     = IDLE;
        end else if (mem.gnt) begin
          drop_req  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem.rvalid) begin
          wb_fire   = 1'b1;
          state_nxt = IDLE;
          if (mem.err) begin
            wb_exc_d      = 1'b1;
            wb_cause_d    = CAUSE_BUS_ERR;
            wb_exc_addr_d = addr_q;
          end else if (!store_q) begin
            wb_rd_wen_d = rd_wen_q;
            wb_data_d   = load_data;
          end
        end else if (expired) begin
          wb_fire       = 1'b1;
          wb_exc_d      = 1'b1;
          wb_cause_d    = CAUSE_TIMEOUT;
          wb_exc_addr_d = addr_q;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture transaction context when a memory request is issued
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      size_q    <= '0;
      uns_q     <= 1'b0;
      rd_wen_q  <= 1'b0;
      rd_addr_q <= '0;
      addr_q    <= '0;
      store_q   <= 1'b0;
    end else if (issue) begin
      size_q    <= i_mem_size;
      uns_q     <= i_mem_unsigned;
      rd_wen_q  <= i_rd_wen;
      rd_addr_q <= i_rd_addr;
      addr_q    <= i_mem_addr;
      store_q   <= i_mem_wreq;
    end
  end

  // Watchdog: cleared on issue, counts while a transaction is outstanding
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys)                          cnt <= '0;
    else if (issue)                        cnt <= '0;
    else if (state == REQ || state == WAIT) cnt <= cnt_inc;
  end

  // Memory request registers: held from issue until grant or timeout
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.be    <= '0;
      mem.wdata <= '0;
    end else if (issue) begin
      mem.req   <= 1'b1;
      mem.we    <= i_mem_wreq;
      mem.addr  <= i_mem_addr & ~(ADDR_W'(LANES - 1));
      mem.be    <= be_in;
      mem.wdata <= i_mem_wreq ? wdata_in : '0;
    end else if (drop_req) begin
      mem.req   <= 1'b0;
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.be    <= '0;
      mem.wdata <= '0;
    end
  end

  // Writeback registers: one-cycle valid pulse, fields hold between pulses
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      o_wb_valid  <= 1'b0;
      o_rd_wen    <= 1'b0;
      o_rd_addr   <= '0;
      o_rd_data   <= '0;
      o_exc       <= 1'b0;
      o_exc_cause <= '0;
      o_exc_addr  <= '0;
    end else begin
      o_wb_valid <= wb_fire;
      if (wb_fire) begin
        o_rd_wen    <= wb_rd_wen_d;
        o_rd_addr   <= wb_rd_addr_d;
        o_rd_data   <= wb_data_d;
        o_exc       <= wb_exc_d;
        o_exc_cause <= wb_cause_d;
        o_exc_addr  <= wb_exc_addr_d;
      end
    end
  end

endmodule
